// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
//   lsu_state_e    : LSU FSM states (IDLE/REQ/WAIT/DONE)
//   funct3_load_e  : load funct3 encodings
//   funct3_store_e : store funct3 encodings
//   access_size_e  : decoded access width
//   BE_WIDTH       : byte-enable width of the data path
//   access_size()  : funct3 -> access width; undefined encodings map to word
package riscv_lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = LSU_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_load_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } funct3_store_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  function automatic access_size_e access_size(input logic we, input logic [2:0] funct3);
    access_size_e size;
    size = SZ_WORD;
    if (we) begin
      case (funct3)
        SB:      size = SZ_BYTE;
        SH:      size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        LB, LBU: size = SZ_BYTE;
        LH, LHU: size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/riscv_load_extend.sv
// Load data extraction: shifts the addressed lane down to bit 0 and applies
// sign or zero extension according to the load funct3.
//   funct3 : load funct3 (undefined values behave as LW)
//   offset : byte offset addr[1:0] of the access
//   rdata  : raw word returned by the data memory
//   result : extended load data
module riscv_load_extend
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] result
);

  access_size_e          size;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign;

  always_comb begin
    size = access_size(1'b0, funct3);
    // Halfwords only honour addr[1]; words ignore the offset entirely.
    case (size)
      SZ_BYTE: lane = offset;
      SZ_HALF: lane = {offset[1], 1'b0};
      default: lane = 2'b00;
    endcase
    shifted = rdata >> {lane, 3'b000};
    sign    = 1'b0;
    result  = shifted;
    case (size)
      SZ_BYTE: begin
        sign   = ~funct3[2] & shifted[7];
        result = {{(DATA_WIDTH-8){sign}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sign   = ~funct3[2] & shifted[15];
        result = {{(DATA_WIDTH-16){sign}}, shifted[15:0]};
      end
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit for the RV32I core. Accepts one decoded memory operation
// at a time, runs a req/gnt/rvalid handshake with a single-port data memory
// and returns extended load data with a one-cycle completion pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// complete with rsp_err_o=1 and issue no memory request).
//   clk, rst                : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : core request handshake
//   req_we_i, req_funct3_i  : store/load select and width encoding
//   req_addr_i, req_wdata_i : effective byte address, rs2 store data
//   rsp_valid_o, rsp_rdata_o, rsp_err_o : completion pulse, load data, error
//   busy_o                  : operation in flight
//   mem_*                   : data memory request/response port
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e            state_q, state_d;
  logic                  op_we_q;
  logic [2:0]            op_funct3_q;
  logic [1:0]            op_off_q;
  access_size_e          req_size;
  logic [BE_WIDTH-1:0]   req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_trap;
  logic                  accept;
  logic [DATA_WIDTH-1:0] load_data;

  // Byte enables and lane-replicated store data are computed from the
  // incoming request and registered at accept, so the memory side is a
  // stable register output for the whole REQ phase.
  always_comb begin
    req_size  = access_size(req_we_i, req_funct3_i);
    req_be    = '1;
    req_wdata = req_wdata_i;
    if (req_we_i) begin
      case (req_size)
        SZ_BYTE: begin
          req_be    = BE_WIDTH'(1) << req_addr_i[1:0];
          req_wdata = {(DATA_WIDTH/8){req_wdata_i[7:0]}};
        end
        SZ_HALF: begin
          req_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
          req_wdata = {(DATA_WIDTH/16){req_wdata_i[15:0]}};
        end
        default: req_be = '1;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  always_comb begin
    req_trap = ((req_size == SZ_HALF) && req_addr_i[0]) ||
               ((req_size == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
  end
  assign rsp_err_o = (state_q == DONE) && err_q;
`else
  assign req_trap  = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  assign accept      = (state_q == IDLE) && req_valid_i;
  assign req_ready_o = (state_q == IDLE) && !rst;
  assign busy_o      = (state_q != IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign rsp_valid_o = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = req_trap ? DONE : REQ;
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: if (mem_rvalid_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  riscv_load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .funct3 (op_funct3_q),
    .offset (op_off_q),
    .rdata  (mem_rdata_i),
    .result (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_we_q     <= 1'b0;
      op_funct3_q <= '0;
      op_off_q    <= '0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rsp_rdata_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_we_q     <= req_we_i;
        op_funct3_q <= req_funct3_i;
        op_off_q    <= req_addr_i[1:0];
        mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
        mem_we_o    <= req_we_i;
        mem_be_o    <= req_be;
        mem_wdata_o <= req_wdata;
        if (req_trap) rsp_rdata_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        err_q       <= req_trap;
`endif
      end
      if ((state_q == WAIT) && mem_rvalid_i) begin
        rsp_rdata_o <= op_we_q ? '0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  riscv_lsu #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned gnt_delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int unsigned gd,
                              input logic [31:0] ea, input logic [3:0] eb,
                              input logic [31:0] ew, input logic [31:0] er);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.gnt_delay = gd; v.exp_addr = ea; v.exp_be = eb;
    v.exp_wdata = ew; v.exp_rdata = er;
    return v;
  endfunction

  // One full transaction: accept, REQ (with optional grant stall during
  // which a stray rvalid must be ignored), WAIT, DONE pulse, back to IDLE.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    check({v.name, " ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = v.we;
    req_funct3_i = v.f3;
    req_addr_i   = v.addr;
    req_wdata_i  = v.wdata;
    @(negedge clk);
    req_valid_i  = 1'b0;
    req_addr_i   = 32'hFFFF_FFFF;
    req_wdata_i  = 32'h0BAD_0BAD;
    check({v.name, " mem_req"}, 32'(mem_req_o), 32'd1);
    check({v.name, " addr"},    mem_addr_o, v.exp_addr);
    check({v.name, " be"},      32'(mem_be_o), 32'(v.exp_be));
    check({v.name, " we"},      32'(mem_we_o), 32'(v.we));
    if (v.we) check({v.name, " wdata"}, mem_wdata_o, v.exp_wdata);
    for (int unsigned i = 0; i < v.gnt_delay; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
      @(negedge clk);
      check({v.name, " stall mem_req"}, 32'(mem_req_o), 32'd1);
      check({v.name, " stall addr"},    mem_addr_o, v.exp_addr);
      check({v.name, " stall be"},      32'(mem_be_o), 32'(v.exp_be));
    end
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    @(negedge clk);
    mem_gnt_i    = 1'b0;
    check({v.name, " wait mem_req"}, 32'(mem_req_o), 32'd0);
    check({v.name, " wait rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = v.we ? 32'h5A5A_5A5A : v.rdata;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h1357_9BDF;
    check({v.name, " rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    check({v.name, " rdata"},     rsp_rdata_o, v.exp_rdata);
    check({v.name, " err"},       32'(rsp_err_o), 32'd0);
    check({v.name, " done ready"}, 32'(req_ready_o), 32'd0);
    @(negedge clk);
    check({v.name, " pulse end"}, 32'(rsp_valid_o), 32'd0);
    check({v.name, " rdata hold"}, rsp_rdata_o, v.exp_rdata);
    check({v.name, " idle busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    vecs.push_back(mk("SB 0x1003", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0,
                      32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0));
    vecs.push_back(mk("SB 0x3001", 1'b1, 3'b000, 32'h0000_3001, 32'h1234_561C, 0, 1,
                      32'h0000_3000, 4'b0010, 32'h1C1C_1C1C, 32'h0));
    vecs.push_back(mk("SH 0x1006", 1'b1, 3'b001, 32'h0000_1006, 32'h1234_CDEF, 0, 0,
                      32'h0000_1004, 4'b1100, 32'hCDEF_CDEF, 32'h0));
    vecs.push_back(mk("SW 0x100C", 1'b1, 3'b010, 32'h0000_100C, 32'h89AB_CDEF, 0, 0,
                      32'h0000_100C, 4'b1111, 32'h89AB_CDEF, 32'h0));
    vecs.push_back(mk("S f3=011", 1'b1, 3'b011, 32'h0000_3000, 32'h55AA_00FF, 0, 0,
                      32'h0000_3000, 4'b1111, 32'h55AA_00FF, 32'h0));
    vecs.push_back(mk("LB 0x2001", 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 0,
                      32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_FF80));
    vecs.push_back(mk("LBU 0x2001", 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 0,
                      32'h0000_2000, 4'b1111, 32'h0, 32'h0000_0080));
    vecs.push_back(mk("LB 0x2003", 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h7F00_0000, 0,
                      32'h0000_2000, 4'b1111, 32'h0, 32'h0000_007F));
    vecs.push_back(mk("LH 0x2002", 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 3,
                      32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_8001));
    vecs.push_back(mk("LHU 0x2002", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 0,
                      32'h0000_2000, 4'b1111, 32'h0, 32'h0000_8001));
    vecs.push_back(mk("LW 0x2004", 1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 2,
                      32'h0000_2004, 4'b1111, 32'h0, 32'hCAFE_F00D));
    vecs.push_back(mk("L f3=111", 1'b0, 3'b111, 32'h0000_2008, 32'h0, 32'h8234_5678, 0,
                      32'h0000_2008, 4'b1111, 32'h0, 32'h8234_5678));
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("LH misal 0x2003", 1'b0, 3'b001, 32'h0000_2003, 32'h0, 32'hFFEE_1122, 0,
                      32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_FFEE));
    vecs.push_back(mk("LW misal 0x2002", 1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'hA1B2_C3D4, 0,
                      32'h0000_2000, 4'b1111, 32'h0, 32'hA1B2_C3D4));
    vecs.push_back(mk("SH misal 0x1007", 1'b1, 3'b001, 32'h0000_1007, 32'h0000_BEEF, 0, 0,
                      32'h0000_1004, 4'b1100, 32'hBEEF_BEEF, 32'h0));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst ready",     32'(req_ready_o), 32'd0);
    check("rst mem_req",   32'(mem_req_o), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst err",       32'(rsp_err_o), 32'd0);
    check("rst busy",      32'(busy_o), 32'd0);
    check("rst mem_we",    32'(mem_we_o), 32'd0);
    check("rst be",        32'(mem_be_o), 32'd0);
    check("rst addr",      mem_addr_o, 32'd0);
    check("rst wdata",     mem_wdata_o, 32'd0);
    check("rst rdata",     rsp_rdata_o, 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst ready", 32'(req_ready_o), 32'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset during WAIT, then a late rvalid must not produce a response.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h0000_4000; req_wdata_i = '0;
    @(negedge clk);
    req_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    check("rstwait busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait ready in rst", 32'(req_ready_o), 32'd0);
    check("rstwait mem_req", 32'(mem_req_o), 32'd0);
    check("rstwait busy idle", 32'(busy_o), 32'd0);
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h7777_7777;
    #1;
    check("rstwait ready after", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("rstwait no rsp", 32'(rsp_valid_o), 32'd0);
    check("rstwait rdata", rsp_rdata_o, 32'd0);
    @(negedge clk);
    check("rstwait no rsp2", 32'(rsp_valid_o), 32'd0);
    check("rstwait idle", 32'(busy_o), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned LW: IDLE -> DONE with error, no memory request.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h0000_2002;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("trap mem_req", 32'(mem_req_o), 32'd0);
    check("trap rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("trap err", 32'(rsp_err_o), 32'd1);
    check("trap rdata", rsp_rdata_o, 32'd0);
    @(negedge clk);
    check("trap pulse end", 32'(rsp_valid_o), 32'd0);
    check("trap err end", 32'(rsp_err_o), 32'd0);
    check("trap mem_req end", 32'(mem_req_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
